pixel_byte_packer: RTL and testbench
====================================

// Module: pixel_byte_packer
// PURPOSE
//  Front-end input stage of the grayscale/Sobel pipeline. Collects pixel bytes arriving on the
//  8-bit chip input bus and assembles them into a MAX_PIXEL_BITS-wide pixel word plus a
//  one-cycle ready pulse. The pixel word drives the pipeline's pixel input; the ready pulse
//  drives the pipeline's pixel-ready input.
//  Bytes per pixel follow the pipeline mode: 1 byte (pre-gray) in Sobel-only mode
//  (select = 2'b01), BYTES_PER_PX bytes (RGB) in every other mode.
// PARAMETERS
//  BYTE_W          8   width of one input byte
//  BYTES_PER_PX    3   bytes per RGB pixel; MAX_PIXEL_BITS = BYTE_W*BYTES_PER_PX
//  MAX_PIXEL_BITS  24  assembled pixel width; must equal BYTE_W*BYTES_PER_PX
// PORTS
//  clk_i         in   1               clock
//  nreset_i      in   1               asynchronous, active-low reset
//  clear_i       in   1               sync abort: drop partial pixel, zero pixel counter
//  select_i      in   2               pipeline mode; 2'b01 = 1 byte/pixel, else BYTES_PER_PX
//  byte_i        in   BYTE_W          input byte
//  byte_vld_i    in   1               byte_i valid this cycle; always accepted, no back-pressure
//  pixel_o       out  MAX_PIXEL_BITS  assembled pixel, held until the next pixel completes
//  px_rdy_o      out  1               one-cycle pulse: pixel_o is new this cycle
//  busy_o        out  1               high while a partial pixel is held (state COLLECT)
//  px_count_o    out  16              pixels emitted since reset/clear, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async): state IDLE; pixel_o, px_rdy_o, busy_o, px_count_o, byte index, shift reg all 0.
//  FSM states: IDLE, COLLECT.
//   IDLE, byte_vld_i: latch mode n = (select_i==2'b01) ? 1 : BYTES_PER_PX.
//     n==1: emit immediately, stay IDLE.
//     else: store byte, idx=1, go COLLECT.
//   COLLECT, byte_vld_i: store byte, idx++.
//     idx reaches n: emit, go IDLE.
//   COLLECT, no byte_vld_i: hold state; no timeout.
//  Byte order: first byte is MSB (R); RGB pixel = {b0,b1,b2}.
//   1-byte mode: pixel_o = {{(MAX_PIXEL_BITS-BYTE_W){1'b0}}, b0}, i.e. the byte sits in [7:0].
//  Emit: registered. On the clock edge that accepts the last byte, update pixel_o and set
//   px_rdy_o=1 for exactly one cycle. Latency is 1 cycle from the last byte's valid to px_rdy_o.
//   pixel_o is never partially updated; partial bytes live in an internal shift reg.
//  Back-to-back: a byte_vld_i in the emit cycle (px_rdy_o high) is the first byte of the next
//   pixel. No bubble. Max rate: one pixel per n cycles.
//  select_i is sampled only on the first byte of a pixel; changes mid-pixel are ignored until
//   the next IDLE.
//  px_count_o increments on each emit, width 16, wraps 0xFFFF->0x0000 silently.
//  clear_i (sync) has priority over byte_vld_i in the same cycle. It:
//   - sets state IDLE, idx 0, px_count_o 0, px_rdy_o 0;
//   - leaves pixel_o unchanged;
//   - discards the byte presented that cycle.
//  Reset mid-pixel: partial bytes lost; the first byte after deassertion starts a new pixel.
//  busy_o = (state==COLLECT), registered.
// TESTING
//  1 RGB: select=00, bytes 0x12,0x34,0x56 on consecutive cycles
//     -> px_rdy_o one cycle after 0x56, pixel_o=0x123456, px_count_o=1.
//  2 Sobel-only: select=01, bytes 0xAB,0xCD back-to-back
//     -> two px_rdy_o pulses on consecutive cycles, pixel_o=0x0000AB then 0x0000CD.
//  3 Gaps + mode change: select=10, 0x11 / idle 5 / select->01 / 0x22 / idle / 0x33
//     -> busy_o high throughout, single emit pixel_o=0x112233.
//  4 Clear: 0xAA,0xBB then clear_i together with 0xCC
//     -> no px_rdy_o, busy_o=0, px_count_o=0; then 0x01,0x02,0x03 -> pixel_o=0x010203.
//  5 Async reset after 2 bytes of a pixel -> all outputs 0 immediately;
//     then 3 bytes -> one correct pixel.
//  6 Wrap: force 65536 1-byte pixels -> px_count_o returns to 0x0000 with no error.

Source files
------------

// File: rtl/pixel_byte_packer.sv
// pixel_byte_packer: assembles incoming 8-bit bytes into one pixel word for the
// grayscale/Sobel pipeline. It takes one byte per pixel in Sobel-only mode and
// BYTES_PER_PX bytes (RGB, first byte most significant) in every other mode.
// A completed pixel is presented on pixel_o with a one-cycle px_rdy_o pulse.
module pixel_byte_packer #(
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_PX   = 3,
    parameter int MAX_PIXEL_BITS = 24
) (
    input  logic                      clk_i,
    input  logic                      nreset_i,
    input  logic                      clear_i,
    input  logic [1:0]                select_i,
    input  logic [BYTE_W-1:0]         byte_i,
    input  logic                      byte_vld_i,
    output logic [MAX_PIXEL_BITS-1:0] pixel_o,
    output logic                      px_rdy_o,
    output logic                      busy_o,
    output logic [15:0]               px_count_o
);

    localparam int IDX_W   = $clog2(BYTES_PER_PX + 1);
    localparam int SHIFT_W = MAX_PIXEL_BITS - BYTE_W;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [SHIFT_W-1:0]        shift_q, shift_d;
    logic [MAX_PIXEL_BITS-1:0] pixel_q, pixel_d;
    logic                      px_rdy_q, px_rdy_d;
    logic [15:0]               count_q, count_d;

    logic one_byte_mode;
    logic last_byte;

    // The mode only matters on the first byte; COLLECT always means a multi-byte pixel.
    assign one_byte_mode = (select_i == 2'b01);
    assign last_byte     = (state_q == COLLECT) && (idx_q == IDX_W'(BYTES_PER_PX - 1));

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear aborts any partial pixel, otherwise each valid byte advances.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else if (byte_vld_i) begin
            case (state_q)
                IDLE:    if (!one_byte_mode) state_d = COLLECT;
                COLLECT: if (last_byte)      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: shift in partial bytes, emit the whole pixel on the last byte.
    always_comb begin
        idx_d    = idx_q;
        shift_d  = shift_q;
        pixel_d  = pixel_q;
        px_rdy_d = 1'b0;
        count_d  = count_q;
        if (clear_i) begin
            idx_d   = '0;
            shift_d = '0;
            count_d = '0;
        end else if (byte_vld_i) begin
            case (state_q)
                IDLE: begin
                    if (one_byte_mode) begin
                        pixel_d  = MAX_PIXEL_BITS'(byte_i);
                        px_rdy_d = 1'b1;
                        count_d  = count_q + 16'd1;
                        idx_d    = '0;
                    end else begin
                        shift_d = SHIFT_W'(byte_i);
                        idx_d   = IDX_W'(1);
                    end
                end
                COLLECT: begin
                    if (last_byte) begin
                        pixel_d  = {shift_q, byte_i};
                        px_rdy_d = 1'b1;
                        count_d  = count_q + 16'd1;
                        idx_d    = '0;
                    end else begin
                        shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], byte_i};
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
                default: idx_d = '0;
            endcase
        end
    end

    // Datapath registers; reset zeroes everything so no partial pixel survives.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            idx_q    <= '0;
            shift_q  <= '0;
            pixel_q  <= '0;
            px_rdy_q <= 1'b0;
            count_q  <= '0;
        end else begin
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            pixel_q  <= pixel_d;
            px_rdy_q <= px_rdy_d;
            count_q  <= count_d;
        end
    end

    assign pixel_o    = pixel_q;
    assign px_rdy_o   = px_rdy_q;
    assign busy_o     = (state_q == COLLECT);
    assign px_count_o = count_q;

endmodule

// File: tb/tb_pixel_byte_packer.sv
// tb_pixel_byte_packer: directed scenarios plus random traffic for pixel_byte_packer.
// A byte-list reference model predicts each pixel; a monitor compares DUT output.
module tb_pixel_byte_packer;

    logic        clk_i = 1'b0;
    logic        nreset_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [1:0]  select_i = 2'b00;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_vld_i = 1'b0;
    logic [23:0] pixel_o;
    logic        px_rdy_o;
    logic        busy_o;
    logic [15:0] px_count_o;

    int compared = 0;
    int mismatched = 0;

    // Reference model state: bytes of the pixel in progress and what has been emitted.
    logic [7:0]  pend[$];
    int          modelN = 0;
    logic [15:0] modelCount = 16'd0;
    logic [23:0] modelPixel = 24'd0;
    logic [39:0] expQ[$];

    pixel_byte_packer dut (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .clear_i    (clear_i),
        .select_i   (select_i),
        .byte_i     (byte_i),
        .byte_vld_i (byte_vld_i),
        .pixel_o    (pixel_o),
        .px_rdy_o   (px_rdy_o),
        .busy_o     (busy_o),
        .px_count_o (px_count_o)
    );

    // 10 ns clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [7:0] b, input logic [1:0] sel, input logic clr);
        @(posedge clk_i);
        #1;
        byte_vld_i = vld;
        byte_i     = b;
        select_i   = sel;
        clear_i    = clr;
    endtask

    task automatic pulseReset();
        #1;
        nreset_i = 1'b0;
        #1;
        checkOutput("rstPixel", 32'(pixel_o), 32'h0);
        checkOutput("rstRdy", 32'(px_rdy_o), 32'h0);
        checkOutput("rstBusy", 32'(busy_o), 32'h0);
        checkOutput("rstCount", 32'(px_count_o), 32'h0);
        #3;
        nreset_i = 1'b1;
    endtask

    // Reference model: collect bytes into a list; when the list reaches the pixel
    // length chosen at its first byte, concatenate it arithmetically and queue it.
    always @(posedge clk_i or negedge nreset_i) begin
        logic [23:0] pix;
        if (!nreset_i) begin
            pend.delete();
            modelN     = 0;
            modelCount = 16'd0;
            modelPixel = 24'd0;
            expQ.delete();
        end else if (clear_i) begin
            pend.delete();
            modelCount = 16'd0;
        end else if (byte_vld_i) begin
            if (pend.size() == 0) modelN = (select_i == 2'b01) ? 1 : 3;
            pend.push_back(byte_i);
            if (pend.size() == modelN) begin
                pix = 24'd0;
                foreach (pend[i]) pix = pix * 24'd256 + 24'(pend[i]);
                modelCount = modelCount + 16'd1;
                modelPixel = pix;
                expQ.push_back({pix, modelCount});
                pend.delete();
            end
        end
    end

    // Monitor: on the falling edge, pop the scoreboard on each ready pulse and track held outputs.
    always @(negedge clk_i) begin
        logic [39:0] exp;
        checkOutput("rdyPulse", 32'(px_rdy_o), 32'(expQ.size() != 0));
        if (px_rdy_o && expQ.size() != 0) begin
            exp = expQ.pop_front();
            checkOutput("sbPixel", 32'(pixel_o), 32'(exp[39:16]));
            checkOutput("sbCount", 32'(px_count_o), 32'(exp[15:0]));
        end
        checkOutput("heldPixel", 32'(pixel_o), 32'(modelPixel));
        checkOutput("busy", 32'(busy_o), 32'(pend.size() != 0));
        checkOutput("count", 32'(px_count_o), 32'(modelCount));
    end

    initial begin
        #3;
        checkOutput("initPixel", 32'(pixel_o), 32'h0);
        checkOutput("initRdy", 32'(px_rdy_o), 32'h0);
        checkOutput("initBusy", 32'(busy_o), 32'h0);
        checkOutput("initCount", 32'(px_count_o), 32'h0);
        #4;
        nreset_i = 1'b1;

        // RGB pixel from three consecutive bytes.
        applyStimulus(1'b1, 8'h12, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'h34, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'h56, 2'b00, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        checkOutput("t1Pixel", 32'(pixel_o), 32'h123456);
        checkOutput("t1Rdy", 32'(px_rdy_o), 32'h1);
        checkOutput("t1Count", 32'(px_count_o), 32'h1);

        // Sobel-only, two back-to-back single-byte pixels.
        applyStimulus(1'b1, 8'hAB, 2'b01, 1'b0);
        applyStimulus(1'b1, 8'hCD, 2'b01, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b01, 1'b0);
        checkOutput("t2Pixel", 32'(pixel_o), 32'h0000CD);
        checkOutput("t2Count", 32'(px_count_o), 32'h3);

        // Gaps and a mid-pixel mode change that must be ignored.
        applyStimulus(1'b1, 8'h11, 2'b10, 1'b0);
        repeat (5) applyStimulus(1'b0, 8'h00, 2'b10, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b01, 1'b0);
        applyStimulus(1'b1, 8'h22, 2'b01, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b01, 1'b0);
        checkOutput("t3Busy", 32'(busy_o), 32'h1);
        applyStimulus(1'b1, 8'h33, 2'b01, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        checkOutput("t3Pixel", 32'(pixel_o), 32'h112233);

        // Clear discards a partial pixel and the byte presented with it.
        applyStimulus(1'b1, 8'hAA, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'hBB, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'hCC, 2'b00, 1'b1);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        checkOutput("t4Rdy", 32'(px_rdy_o), 32'h0);
        checkOutput("t4Busy", 32'(busy_o), 32'h0);
        checkOutput("t4Count", 32'(px_count_o), 32'h0);
        checkOutput("t4Held", 32'(pixel_o), 32'h112233);
        applyStimulus(1'b1, 8'h01, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'h02, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'h03, 2'b00, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        checkOutput("t4Pixel", 32'(pixel_o), 32'h010203);

        // Asynchronous reset in the middle of a pixel.
        applyStimulus(1'b1, 8'h77, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'h88, 2'b00, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        pulseReset();
        applyStimulus(1'b1, 8'h9A, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'hBC, 2'b00, 1'b0);
        applyStimulus(1'b1, 8'hDE, 2'b00, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        checkOutput("t5Pixel", 32'(pixel_o), 32'h9ABCDE);
        checkOutput("t5Count", 32'(px_count_o), 32'h1);

        // Random traffic: modes, gaps, occasional clears.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), 8'($urandom), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 49) == 0));
        end

        // Counter wrap: clear, then 65536 single-byte pixels.
        applyStimulus(1'b0, 8'h00, 2'b01, 1'b1);
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b1, 8'(i), 2'b01, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 2'b01, 1'b0);
        checkOutput("t6Count", 32'(px_count_o), 32'h0);
        checkOutput("t6Pixel", 32'(pixel_o), 32'h0000FF);

        repeat (3) applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        checkOutput("sbDrain", 32'(expQ.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
